// File: rtl/edu_pkg.sv
// Shared constants for the edu BAR0 register back-end: register offsets,
// status/irq bit positions, local-bus state encoding and a byte-mask helper.
package edu_pkg;

    localparam logic [7:0] OFF_IDENT      = 8'h00;
    localparam logic [7:0] OFF_LIVE       = 8'h04;
    localparam logic [7:0] OFF_FACT       = 8'h08;
    localparam logic [7:0] OFF_STATUS     = 8'h20;
    localparam logic [7:0] OFF_IRQ_STATUS = 8'h24;
    localparam logic [7:0] OFF_RAISE      = 8'h60;
    localparam logic [7:0] OFF_ACK        = 8'h64;

    localparam int STATUS_BUSY   = 0;
    localparam int STATUS_IRQ_EN = 7;
    localparam int IRQ_FACT_DONE = 0;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } bus_state_t;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/edu_mmio_if.sv
// Local bus from the pci target core to the edu register file.
// valid/ready: the master raises lb_valid with lb_write/addr/wdata/be and holds them stable until it sees lb_ready, a one-cycle pulse; lb_rdata is meaningful only while lb_ready=1.
interface edu_mmio_if;
    logic        lb_valid;
    logic        lb_write;
    logic [7:0]  lb_addr;
    logic [31:0] lb_wdata;
    logic [3:0]  lb_be;
    logic        lb_ready;
    logic [31:0] lb_rdata;

    modport master (
        output lb_valid, lb_write, lb_addr, lb_wdata, lb_be,
        input  lb_ready, lb_rdata
    );

    modport slave (
        input  lb_valid, lb_write, lb_addr, lb_wdata, lb_be,
        output lb_ready, lb_rdata
    );
endinterface

// File: rtl/edu_fact.sv
// Iterative factorial engine: one 32-bit multiply per cycle, result = n! mod 2^32.
// done pulses on the edge where busy clears so the irq logic can latch it on that edge.
module edu_fact (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] operand,
    input  logic [31:0] mask,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    logic [31:0] counter_q;
    logic [31:0] result_q;
    logic        busy_q;

    // Last multiply happens with counter=2; counters 0/1 finish without one.
    assign done   = busy_q && (counter_q <= 32'd2);
    assign busy   = busy_q;
    assign result = result_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter_q <= 32'h0;
            result_q  <= 32'h0;
            busy_q    <= 1'b0;
        end else if (start) begin
            counter_q <= (counter_q & ~mask) | (operand & mask);
            result_q  <= 32'h1;
            busy_q    <= 1'b1;
        end else if (busy_q) begin
            if (counter_q > 32'd1) begin
                result_q  <= result_q * counter_q;
                counter_q <= counter_q - 32'd1;
            end
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/edu_mmio.sv
// edu device BAR0 register file: address decode, ident/liveness/status/irq
// registers, local-bus response and the level interrupt to the pci core.
module edu_mmio
    import edu_pkg::*;
#(
    parameter logic [31:0] IDENT = 32'h010000ed
) (
    input  logic       clk,
    input  logic       rst,
    edu_mmio_if.slave  lb,
    output logic       irq,
    output bus_state_t dbg_state
);

    bus_state_t  state_q, state_d;
    logic        accept;
    logic        wr, rd;
    logic [7:0]  word_addr;
    logic [31:0] mask;
    logic        ready_q;
    logic [31:0] rdata_q, rd_data, status;
    logic [31:0] live_q;
    logic        irq_en_q;
    logic [31:0] isr_q, isr_d, raise_bits, ack_bits, done_bits;
    logic        fact_start, fact_busy, fact_done;
    logic [31:0] fact_result;
    logic        unused_addr_lsb;

    assign word_addr       = {lb.lb_addr[7:2], 2'b00};
    assign unused_addr_lsb = ^lb.lb_addr[1:0];
    assign mask            = be_mask(lb.lb_be);
    assign wr              = accept && lb.lb_write;
    assign rd              = accept && !lb.lb_write;
    assign fact_start      = wr && (word_addr == OFF_FACT) && !fact_busy;

    assign lb.lb_ready = ready_q;
    assign lb.lb_rdata = rdata_q;
    assign dbg_state   = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Requests are only sampled in IDLE, so the response cycle never re-accepts a held request.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (lb.lb_valid) begin
                accept  = 1'b1;
                state_d = RESP;
            end
            RESP: state_d = IDLE;
        endcase
    end

    always_comb begin
        status                = 32'h0;
        status[STATUS_BUSY]   = fact_busy;
        status[STATUS_IRQ_EN] = irq_en_q;
        rd_data               = 32'hFFFF_FFFF;
        case (word_addr)
            OFF_IDENT:      rd_data = IDENT;
            OFF_LIVE:       rd_data = ~live_q;
            OFF_FACT:       rd_data = fact_result;
            OFF_STATUS:     rd_data = status;
            OFF_IRQ_STATUS: rd_data = isr_q;
            default:        rd_data = 32'hFFFF_FFFF;
        endcase
    end

    // Completion is OR-ed in after the ack so it wins a same-edge ack of its bit.
    always_comb begin
        raise_bits = 32'h0;
        ack_bits   = 32'h0;
        done_bits  = 32'h0;
        if (wr && word_addr == OFF_RAISE) raise_bits = lb.lb_wdata & mask;
        if (wr && word_addr == OFF_ACK)   ack_bits   = lb.lb_wdata & mask;
        if (fact_done && irq_en_q)        done_bits[IRQ_FACT_DONE] = 1'b1;
        isr_d = ((isr_q | raise_bits) & ~ack_bits) | done_bits;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q  <= 1'b0;
            rdata_q  <= 32'h0;
            live_q   <= 32'h0;
            irq_en_q <= 1'b0;
            isr_q    <= 32'h0;
            irq      <= 1'b0;
        end else begin
            ready_q <= accept;
            rdata_q <= rd ? rd_data : 32'h0;
            if (wr && word_addr == OFF_LIVE)
                live_q <= (live_q & ~mask) | (lb.lb_wdata & mask);
            if (wr && word_addr == OFF_STATUS && lb.lb_be[0])
                irq_en_q <= lb.lb_wdata[STATUS_IRQ_EN];
            isr_q <= isr_d;
            irq   <= |isr_q;
        end
    end

    edu_fact u_fact (
        .clk     (clk),
        .rst     (rst),
        .start   (fact_start),
        .operand (lb.lb_wdata),
        .mask    (mask),
        .busy    (fact_busy),
        .done    (fact_done),
        .result  (fact_result)
    );

endmodule

// File: tb/tb_edu_mmio.sv
// Bench for edu_mmio: reset values, a register-map vector table, hand-written
// factorial/irq/reset sequences and random traffic against a timestamp model.
module tb_edu_mmio;
    import edu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       irq;
    bus_state_t dbg_state;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    edu_mmio_if bus ();

    edu_mmio #(.IDENT(32'h010000ed)) dut (
        .clk       (clk),
        .rst       (rst),
        .lb        (bus),
        .irq       (irq),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    endtask

    // ---------------- reference model (timestamped, register-map level) ----------------
    logic [31:0] m_live, m_isr;
    logic        m_en, m_act, m_pend;
    int          m_t, m_d, m_n;

    task automatic m_reset();
        m_live = 0; m_isr = 0; m_en = 0; m_act = 0; m_pend = 0;
        m_t = 0; m_d = 0; m_n = 0;
    endtask

    function automatic logic [31:0] partial(input int n, input int k);
        logic [31:0] r = 32'h1;
        for (int i = 0; i < k; i++) r = r * 32'(n - i);
        return r;
    endfunction

    function automatic logic [31:0] fact_res_at(input int e);
        int k;
        if (!m_act) return 32'h0;
        if (m_n <= 1) return 32'h1;
        k = e - m_t;
        if (k > m_n - 1) k = m_n - 1;
        return partial(m_n, k);
    endfunction

    task automatic settle(input int e);
        if (m_pend && m_d <= e) begin
            m_pend = 0;
            if (m_en) m_isr[0] = 1'b1;
        end
    endtask

    task automatic m_apply(input int n, input logic wr, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           output logic [31:0] exp_rd);
        logic [7:0]  wa;
        logic [31:0] msk, raise, ack;
        logic        comp, busy_prev;
        wa  = {addr[7:2], 2'b00};
        msk = be_mask(be);
        raise = 0; ack = 0; comp = 0;
        settle(n - 1);
        if (m_pend && m_d == n) begin
            m_pend = 0;
            comp = m_en;
        end
        busy_prev = m_act && (n - 1) >= m_t && (n - 1) < m_d;
        case (wa)
            8'h00:   exp_rd = 32'h010000ed;
            8'h04:   exp_rd = ~m_live;
            8'h08:   exp_rd = fact_res_at(n - 1);
            8'h20:   exp_rd = {24'h0, m_en, 6'h0, busy_prev};
            8'h24:   exp_rd = m_isr;
            default: exp_rd = 32'hFFFF_FFFF;
        endcase
        if (wr) begin
            case (wa)
                8'h04: m_live = (m_live & ~msk) | (wdata & msk);
                8'h08: if (!busy_prev) begin
                    m_act = 1; m_pend = 1; m_t = n; m_n = int'(wdata);
                    m_d = n + ((m_n <= 1) ? 1 : m_n - 1);
                end
                8'h20: if (be[0]) m_en = wdata[7];
                8'h60: raise = wdata & msk;
                8'h64: ack = wdata & msk;
                default: ;
            endcase
        end
        m_isr = ((m_isr | raise) & ~ack) | {31'h0, comp};
    endtask

    // ---------------- driver ----------------
    task automatic access(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rd, output logic [31:0] exp);
        int   lat;
        logic got;
        @(negedge clk);
        bus.lb_valid = 1'b1; bus.lb_write = wr; bus.lb_addr = addr;
        bus.lb_wdata = wdata; bus.lb_be = be;
        got = 0; lat = 0; rd = 32'h0; exp = 32'h0;
        while (!got && lat < 4) begin
            @(posedge clk); #1;
            lat++;
            if (bus.lb_ready) got = 1;
        end
        bus.lb_valid = 1'b0;
        if (!got) begin
            check("ready_timeout", 32'h0, 32'h1);
        end else begin
            rd = bus.lb_rdata;
            check("ready_latency", 32'(lat), 32'd1);
            m_apply(cyc - lat + 1, wr, addr, wdata, be, exp);
        end
        @(posedge clk); #1;
        check("ready_pulse", {31'h0, bus.lb_ready}, 32'h0);
    endtask

    task automatic wr32(input logic [7:0] addr, input logic [31:0] data);
        logic [31:0] r, e;
        access(1'b1, addr, data, 4'hF, r, e);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] r, e;
        access(1'b0, addr, 32'h0, 4'hF, r, e);
        check(name, r, exp);
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                                    input logic [3:0] be, input logic [31:0] exp);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be; v.exp = exp;
        vecs.push_back(v);
    endfunction

    logic [7:0] raddr[10] = '{8'h00, 8'h04, 8'h08, 8'h20, 8'h24, 8'h60, 8'h64, 8'h40, 8'h10, 8'h7C};

    initial begin
        logic [31:0] r, e, wd;
        logic [7:0]  a;
        logic [3:0]  be;
        logic        w;

        bus.lb_valid = 0; bus.lb_write = 0; bus.lb_addr = 0; bus.lb_wdata = 0; bus.lb_be = 0;
        m_reset();
        #1 rst = 1'b0;
        #1;
        check("reset_ready", {31'h0, bus.lb_ready}, 32'h0);
        check("reset_rdata", bus.lb_rdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        check("reset_state", {31'h0, dbg_state}, {31'h0, IDLE});
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // register map vectors
        add_vec(0, 8'h00, 0, 4'hF, 32'h010000ed);
        add_vec(0, 8'h04, 0, 4'hF, 32'hFFFFFFFF);
        add_vec(1, 8'h04, 32'hAABBCCDD, 4'b0001, 0);
        add_vec(0, 8'h04, 0, 4'hF, 32'hFFFFFF22);
        add_vec(1, 8'h04, 32'h12345678, 4'hF, 0);
        add_vec(0, 8'h04, 0, 4'hF, 32'hEDCBA987);
        add_vec(1, 8'h06, 32'h00FF0000, 4'b0100, 0);
        add_vec(0, 8'h05, 0, 4'hF, 32'hED00A987);
        add_vec(1, 8'h40, 32'h0, 4'hF, 0);
        add_vec(0, 8'h04, 0, 4'hF, 32'hED00A987);
        add_vec(0, 8'h40, 0, 4'hF, 32'hFFFFFFFF);
        add_vec(0, 8'h60, 0, 4'hF, 32'hFFFFFFFF);
        add_vec(0, 8'h64, 0, 4'hF, 32'hFFFFFFFF);
        add_vec(0, 8'h20, 0, 4'hF, 32'h0);
        add_vec(1, 8'h20, 32'hFFFFFFFF, 4'hF, 0);
        add_vec(0, 8'h20, 0, 4'hF, 32'h80);
        add_vec(1, 8'h20, 32'h0, 4'hF, 0);
        add_vec(0, 8'h20, 0, 4'hF, 32'h0);
        add_vec(0, 8'h24, 0, 4'hF, 32'h0);
        add_vec(1, 8'h60, 32'h0000_0F00, 4'b0010, 0);
        add_vec(0, 8'h24, 0, 4'hF, 32'h0000_0F00);
        add_vec(1, 8'h64, 32'hFFFF_FFFF, 4'hF, 0);
        add_vec(0, 8'h24, 0, 4'hF, 32'h0);
        add_vec(0, 8'h08, 0, 4'hF, 32'h0);
        foreach (vecs[i]) begin
            access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, r, e);
            if (!vecs[i].wr) check($sformatf("vec%0d", i), r, vecs[i].exp);
        end

        // raise / ack drive irq
        wr32(8'h60, 32'h100);
        check("raise_irq", {31'h0, irq}, 32'h1);
        rd_chk("raise_isr", 8'h24, 32'h100);
        wr32(8'h64, 32'h100);
        check("ack_irq", {31'h0, irq}, 32'h0);

        // factorial 5 with completion irq, including an intermediate read
        wr32(8'h20, 32'h80);
        wr32(8'h08, 32'd5);
        rd_chk("f5_busy", 8'h20, 32'h81);
        rd_chk("f5_mid", 8'h08, 32'h3C);
        rd_chk("f5_idle", 8'h20, 32'h80);
        rd_chk("f5_res", 8'h08, 32'h78);
        rd_chk("f5_isr", 8'h24, 32'h1);
        check("f5_irq", {31'h0, irq}, 32'h1);
        wr32(8'h64, 32'h1);
        check("f5_ack_irq", {31'h0, irq}, 32'h0);

        // 13! wraps mod 2^32; a restart while busy is ignored
        wr32(8'h08, 32'd13);
        wr32(8'h08, 32'd3);
        repeat (14) @(posedge clk);
        rd_chk("f13_res", 8'h08, 32'h7328CC00);
        wr32(8'h64, 32'h1);
        wr32(8'h08, 32'd0);
        rd_chk("f0_res", 8'h08, 32'h1);
        rd_chk("f0_idle", 8'h20, 32'h80);
        wr32(8'h08, 32'd1);
        rd_chk("f1_res", 8'h08, 32'h1);

        // write landing exactly on the completion edge is still ignored
        wr32(8'h08, 32'd3);
        wr32(8'h08, 32'd5);
        rd_chk("fdone_edge_res", 8'h08, 32'h6);

        // same-edge ack vs completion, then raise vs completion
        wr32(8'h64, 32'hFFFFFFFF);
        wr32(8'h60, 32'h6);
        wr32(8'h08, 32'd3);
        wr32(8'h64, 32'h7);
        rd_chk("ack_vs_done", 8'h24, 32'h1);
        wr32(8'h64, 32'h1);
        wr32(8'h08, 32'd3);
        wr32(8'h60, 32'h10);
        rd_chk("raise_vs_done", 8'h24, 32'h11);
        wr32(8'h64, 32'hFFFFFFFF);

        // asynchronous reset during a 10! computation and a response cycle
        wr32(8'h04, 32'h5A5A5A5A);
        wr32(8'h60, 32'h2);
        wr32(8'h08, 32'd10);
        @(negedge clk);
        bus.lb_valid = 1'b1; bus.lb_write = 1'b0; bus.lb_addr = 8'h08; bus.lb_be = 4'hF;
        @(posedge clk); #2;
        check("prerst_ready", {31'h0, bus.lb_ready}, 32'h1);
        check("prerst_irq", {31'h0, irq}, 32'h1);
        rst = 1'b0;
        #1;
        bus.lb_valid = 1'b0;
        check("rst_ready", {31'h0, bus.lb_ready}, 32'h0);
        check("rst_rdata", bus.lb_rdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_state", {31'h0, dbg_state}, {31'h0, IDLE});
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        rd_chk("rst_result", 8'h08, 32'h0);
        rd_chk("rst_status", 8'h20, 32'h0);
        rd_chk("rst_isr", 8'h24, 32'h0);
        rd_chk("rst_live", 8'h04, 32'hFFFFFFFF);

        // random traffic against the model
        for (int i = 0; i < 200; i++) begin
            a  = raddr[$urandom_range(0, 9)] | 8'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            wd = $urandom;
            be = 4'($urandom_range(0, 15));
            if (a[7:2] == 6'h02) begin
                wd = 32'($urandom_range(0, 12));
                be = 4'hF;
            end
            access(w, a, wd, be, r, e);
            if (!w) check("rand_rd", r, e);
        end
        repeat (20) @(posedge clk);
        #1;
        settle(cyc);
        check("rand_final_irq", {31'h0, irq}, {31'h0, |m_isr});
        access(1'b0, 8'h24, 32'h0, 4'hF, r, e);
        check("rand_final_isr", r, e);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
